// File: rtl/algo_mrpnwp_rdrsp_buf.sv
// Per-port read-response buffer: credit-gated read issue into the banked memory,
// fixed-latency response capture into a FIFO, and valid/ready return to the client.
module algo_mrpnwp_rdrsp_buf #(
  parameter int WIDTH   = 32,
  parameter int NUMRDPT = 2,
  parameter int BITVBNK = 3,
  parameter int BITVROW = 10,
  parameter int BITPADR = 14,
  parameter int FIFODEP = 4,
  parameter int BITFIFO = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ready,
  input  logic [NUMRDPT-1:0]         cl_read,
  input  logic [NUMRDPT*BITVBNK-1:0] cl_badr,
  input  logic [NUMRDPT*BITVROW-1:0] cl_radr,
  output logic [NUMRDPT-1:0]         cl_rdy,
  output logic [NUMRDPT-1:0]         read,
  output logic [NUMRDPT*BITVBNK-1:0] rd_badr,
  output logic [NUMRDPT*BITVROW-1:0] rd_radr,
  input  logic [NUMRDPT-1:0]         rd_vld,
  input  logic [NUMRDPT*WIDTH-1:0]   rd_dout,
  input  logic [NUMRDPT-1:0]         rd_serr,
  input  logic [NUMRDPT-1:0]         rd_derr,
  input  logic [NUMRDPT*BITPADR-1:0] rd_padr,
  output logic [NUMRDPT-1:0]         out_vld,
  input  logic [NUMRDPT-1:0]         out_rdy,
  output logic [NUMRDPT*WIDTH-1:0]   out_dout,
  output logic [NUMRDPT-1:0]         out_serr,
  output logic [NUMRDPT-1:0]         out_derr,
  output logic [NUMRDPT*BITPADR-1:0] out_padr,
  output logic [NUMRDPT-1:0]         ovf_err,
  output logic [NUMRDPT-1:0]         unx_err
);

  localparam int                 EW   = BITPADR + 2 + WIDTH;
  localparam logic [BITFIFO:0]   DEP  = (BITFIFO+1)'(FIFODEP);
  localparam logic [BITFIFO-1:0] LAST = BITFIFO'(FIFODEP - 1);

  // Handshakes: a request transfers on the edge where cl_read&cl_rdy, a response
  // transfers on the edge where out_vld&out_rdy; out_* hold while out_vld&~out_rdy.
  // The memory side has no backpressure: rd_vld is captured unconditionally.
  assign rd_badr = cl_badr;
  assign rd_radr = cl_radr;

  for (genvar i = 0; i < NUMRDPT; i++) begin : g_port
    logic [BITFIFO:0]   crd;
    logic [BITFIFO:0]   out_cnt;
    logic [BITFIFO:0]   cnt;
    logic [BITFIFO-1:0] wr_ptr;
    logic [BITFIFO-1:0] rd_ptr;
    logic               ovf;
    logic               unx;
    logic               issue;
    logic               pop;
    logic               full;
    logic               push;
    logic [EW-1:0]      head;
    logic [EW-1:0]      mem [FIFODEP];

    assign cl_rdy[i]  = ready & (crd != '0);
    assign issue      = cl_read[i] & cl_rdy[i];
    assign read[i]    = issue;
    assign out_vld[i] = (cnt != '0);
    assign full       = (cnt == DEP);
    assign pop        = out_vld[i] & out_rdy[i];
    // A pop on a full FIFO frees the head slot before the same-edge write lands.
    assign push       = rd_vld[i] & (~full | pop);
    assign head       = out_vld[i] ? mem[rd_ptr] : '0;
    assign {out_padr[i*BITPADR +: BITPADR], out_derr[i], out_serr[i],
            out_dout[i*WIDTH +: WIDTH]} = head;
    assign ovf_err[i] = ovf;
    assign unx_err[i] = unx;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        crd     <= DEP;
        out_cnt <= '0;
        cnt     <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        ovf     <= 1'b0;
        unx     <= 1'b0;
      end else begin
        if (issue && !pop)
          crd <= crd - 1'b1;
        else if (pop && !issue && (crd != DEP))
          crd <= crd + 1'b1;

        if (issue && !rd_vld[i])
          out_cnt <= out_cnt + 1'b1;
        else if (rd_vld[i] && !issue && (out_cnt != '0))
          out_cnt <= out_cnt - 1'b1;

        if (rd_vld[i] && (out_cnt == '0))
          unx <= 1'b1;
        if (rd_vld[i] && full && !pop)
          ovf <= 1'b1;

        if (push && !pop)
          cnt <= cnt + 1'b1;
        else if (pop && !push)
          cnt <= cnt - 1'b1;

        if (push)
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
    end

    // Storage is not reset; the head is gated to zero while empty.
    always_ff @(posedge clk) begin
      if (push)
        mem[wr_ptr] <= {rd_padr[i*BITPADR +: BITPADR], rd_derr[i], rd_serr[i],
                        rd_dout[i*WIDTH +: WIDTH]};
    end
  end

endmodule

// File: tb/tb_algo_mrpnwp_rdrsp_buf.sv
// Bench for algo_mrpnwp_rdrsp_buf: directed steps then random traffic, checked
// against a queue-based model of credits, outstanding reads and the response FIFO.
module tb_algo_mrpnwp_rdrsp_buf;

  localparam int WIDTH   = 32;
  localparam int NUMRDPT = 2;
  localparam int BITVBNK = 3;
  localparam int BITVROW = 10;
  localparam int BITPADR = 14;
  localparam int FIFODEP = 4;
  localparam int BITFIFO = 2;
  localparam int EW      = BITPADR + 2 + WIDTH;
  localparam int LAT     = 3;

  logic                       clk;
  logic                       rst;
  logic                       ready;
  logic [NUMRDPT-1:0]         cl_read;
  logic [NUMRDPT*BITVBNK-1:0] cl_badr;
  logic [NUMRDPT*BITVROW-1:0] cl_radr;
  logic [NUMRDPT-1:0]         cl_rdy;
  logic [NUMRDPT-1:0]         read;
  logic [NUMRDPT*BITVBNK-1:0] rd_badr;
  logic [NUMRDPT*BITVROW-1:0] rd_radr;
  logic [NUMRDPT-1:0]         rd_vld;
  logic [NUMRDPT*WIDTH-1:0]   rd_dout;
  logic [NUMRDPT-1:0]         rd_serr;
  logic [NUMRDPT-1:0]         rd_derr;
  logic [NUMRDPT*BITPADR-1:0] rd_padr;
  logic [NUMRDPT-1:0]         out_vld;
  logic [NUMRDPT-1:0]         out_rdy;
  logic [NUMRDPT*WIDTH-1:0]   out_dout;
  logic [NUMRDPT-1:0]         out_serr;
  logic [NUMRDPT-1:0]         out_derr;
  logic [NUMRDPT*BITPADR-1:0] out_padr;
  logic [NUMRDPT-1:0]         ovf_err;
  logic [NUMRDPT-1:0]         unx_err;

  algo_mrpnwp_rdrsp_buf #(
    .WIDTH(WIDTH), .NUMRDPT(NUMRDPT), .BITVBNK(BITVBNK), .BITVROW(BITVROW),
    .BITPADR(BITPADR), .FIFODEP(FIFODEP), .BITFIFO(BITFIFO)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready), .cl_read(cl_read), .cl_badr(cl_badr),
    .cl_radr(cl_radr), .cl_rdy(cl_rdy), .read(read), .rd_badr(rd_badr),
    .rd_radr(rd_radr), .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_serr(rd_serr),
    .rd_derr(rd_derr), .rd_padr(rd_padr), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_dout(out_dout), .out_serr(out_serr), .out_derr(out_derr),
    .out_padr(out_padr), .ovf_err(ovf_err), .unx_err(unx_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and memory stand-in
  int                 vectors;
  int                 miscompares;
  int                 cyc;
  int                 crd_m [NUMRDPT];
  int                 out_m [NUMRDPT];
  logic               ovf_m [NUMRDPT];
  logic               unx_m [NUMRDPT];
  logic [BITPADR-1:0] padr_next [NUMRDPT];
  logic [EW-1:0]      exp_q [NUMRDPT][$];
  logic [EW-1:0]      mem_q [NUMRDPT][$];
  int                 due_q [NUMRDPT][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NUMRDPT; p++) begin
      crd_m[p] = FIFODEP;
      out_m[p] = 0;
      ovf_m[p] = 1'b0;
      unx_m[p] = 1'b0;
      exp_q[p].delete();
      mem_q[p].delete();
      due_q[p].delete();
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NUMRDPT; p++) begin
      logic          rdy_e;
      logic [EW-1:0] hd;
      rdy_e = ready && (crd_m[p] > 0);
      hd = (exp_q[p].size() > 0) ? exp_q[p][0] : '0;
      chk($sformatf("cl_rdy[%0d]", p), 64'(cl_rdy[p]), 64'(rdy_e));
      chk($sformatf("read[%0d]", p), 64'(read[p]), 64'(cl_read[p] & rdy_e));
      if (cl_read[p] && rdy_e) begin
        chk($sformatf("rd_badr[%0d]", p), 64'(rd_badr[p*BITVBNK +: BITVBNK]),
            64'(cl_badr[p*BITVBNK +: BITVBNK]));
        chk($sformatf("rd_radr[%0d]", p), 64'(rd_radr[p*BITVROW +: BITVROW]),
            64'(cl_radr[p*BITVROW +: BITVROW]));
      end
      chk($sformatf("out_vld[%0d]", p), 64'(out_vld[p]), 64'(exp_q[p].size() > 0));
      chk($sformatf("out_padr[%0d]", p), 64'(out_padr[p*BITPADR +: BITPADR]),
          64'(hd[EW-1 -: BITPADR]));
      chk($sformatf("out_derr[%0d]", p), 64'(out_derr[p]), 64'(hd[WIDTH+1]));
      chk($sformatf("out_serr[%0d]", p), 64'(out_serr[p]), 64'(hd[WIDTH]));
      chk($sformatf("out_dout[%0d]", p), 64'(out_dout[p*WIDTH +: WIDTH]),
          64'(hd[WIDTH-1:0]));
      chk($sformatf("ovf_err[%0d]", p), 64'(ovf_err[p]), 64'(ovf_m[p]));
      chk($sformatf("unx_err[%0d]", p), 64'(unx_err[p]), 64'(unx_m[p]));
    end
  endtask

  // Applies one clock edge worth of the rules to the model.
  task automatic model_update();
    for (int p = 0; p < NUMRDPT; p++) begin
      logic          iss, pop, vld;
      logic [EW-1:0] e;
      iss = cl_read[p] && ready && (crd_m[p] > 0);
      pop = out_rdy[p] && (exp_q[p].size() > 0);
      vld = rd_vld[p];
      if (pop) void'(exp_q[p].pop_front());
      if (vld) begin
        if (exp_q[p].size() < FIFODEP)
          exp_q[p].push_back({rd_padr[p*BITPADR +: BITPADR], rd_derr[p], rd_serr[p],
                              rd_dout[p*WIDTH +: WIDTH]});
        else
          ovf_m[p] = 1'b1;
        if (out_m[p] == 0) unx_m[p] = 1'b1;
      end
      if (iss && !vld) out_m[p]++;
      else if (vld && !iss && out_m[p] > 0) out_m[p]--;
      crd_m[p] = crd_m[p] - int'(iss) + int'(pop);
      if (crd_m[p] > FIFODEP) crd_m[p] = FIFODEP;
      if (crd_m[p] < 0) crd_m[p] = 0;
      if (iss) begin
        e = {padr_next[p], 1'($urandom), 1'($urandom), WIDTH'($urandom)};
        mem_q[p].push_back(e);
        due_q[p].push_back(cyc + LAT);
        padr_next[p]++;
      end
    end
  endtask

  task automatic drive_mem();
    for (int p = 0; p < NUMRDPT; p++) begin
      logic [EW-1:0] e;
      rd_vld[p] = 1'b0;
      e = {BITPADR'($urandom), 1'($urandom), 1'($urandom), WIDTH'($urandom)};
      if (due_q[p].size() > 0 && due_q[p][0] == cyc) begin
        void'(due_q[p].pop_front());
        e = mem_q[p].pop_front();
        rd_vld[p] = 1'b1;
      end
      {rd_padr[p*BITPADR +: BITPADR], rd_derr[p], rd_serr[p], rd_dout[p*WIDTH +: WIDTH]} = e;
      cl_badr[p*BITVBNK +: BITVBNK] = BITVBNK'($urandom);
      cl_radr[p*BITVROW +: BITVROW] = BITVROW'($urandom);
    end
  endtask

  // driver: check mid-cycle, advance the model on the edge, drive 1 time unit later
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst) model_reset();
    else model_update();
    cyc++;
    #1;
    drive_mem();
  endtask

  task automatic inject(input int p, input logic [BITPADR-1:0] padr);
    rd_vld[p] = 1'b1;
    rd_padr[p*BITPADR +: BITPADR] = padr;
    rd_dout[p*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rst = 1'b0;
    ready = 1'b1;
    cl_read = '0;
    cl_badr = '0;
    cl_radr = '0;
    out_rdy = '0;
    rd_vld = '0;
    rd_dout = '0;
    rd_serr = '0;
    rd_derr = '0;
    rd_padr = '0;
    for (int p = 0; p < NUMRDPT; p++) padr_next[p] = '0;
    model_reset();

    // reset state
    repeat (2) cycle();
    #2 rst = 1'b1;
    cycle();
    chk("rst_out_vld", 64'(out_vld), 64'(0));
    chk("rst_cl_rdy", 64'(cl_rdy), 64'(2'b11));

    // fill port 0 with out_rdy low: four accepts, then credits exhausted
    padr_next[0] = 14'h10;
    cl_read = 2'b01;
    repeat (6) cycle();
    cl_read = '0;
    repeat (LAT + 2) cycle();
    chk("full_out_vld", 64'(out_vld[0]), 64'(1));
    chk("full_head_padr", 64'(out_padr[BITPADR-1:0]), 64'(14'h10));
    chk("full_cl_rdy", 64'(cl_rdy[0]), 64'(0));

    // single pop returns one credit
    out_rdy = 2'b01;
    cycle();
    out_rdy = '0;
    chk("pop_cl_rdy", 64'(cl_rdy[0]), 64'(1));
    chk("pop_head_padr", 64'(out_padr[BITPADR-1:0]), 64'(14'h11));
    cl_read = 2'b01;
    cycle();
    cl_read = '0;
    repeat (LAT + 2) cycle();
    chk("refill_ovf", 64'(ovf_err[0]), 64'(0));

    // issue and pop together at the empty-credit boundary, then drain
    cl_read = 2'b01;
    out_rdy = 2'b01;
    repeat (20) cycle();
    cl_read = '0;
    repeat (LAT + 8) cycle();
    out_rdy = '0;
    chk("drain_out_vld", 64'(out_vld[0]), 64'(0));
    chk("drain_cl_rdy", 64'(cl_rdy[0]), 64'(1));

    // unexpected response on port 0
    inject(0, 14'h3aa);
    cycle();
    repeat (3) cycle();
    chk("unx_sticky", 64'(unx_err), 64'(2'b01));
    chk("unx_stored", 64'(out_padr[BITPADR-1:0]), 64'(14'h3aa));
    out_rdy = 2'b01;
    repeat (2) cycle();
    out_rdy = '0;

    // overflow: full FIFO plus a response that bypassed credits
    padr_next[0] = 14'h20;
    cl_read = 2'b01;
    repeat (4) cycle();
    cl_read = '0;
    repeat (LAT + 2) cycle();
    inject(0, 14'h3ff);
    repeat (2) cycle();
    chk("ovf_set", 64'(ovf_err), 64'(2'b01));
    chk("ovf_head_padr", 64'(out_padr[BITPADR-1:0]), 64'(14'h20));

    // asynchronous reset with three entries held
    out_rdy = 2'b01;
    cycle();
    out_rdy = '0;
    cycle();
    chk("pre_rst_head", 64'(out_padr[BITPADR-1:0]), 64'(14'h21));
    #2 rst = 1'b0;
    #1;
    chk("arst_out_vld", 64'(out_vld), 64'(0));
    chk("arst_out_padr", 64'(out_padr), 64'(0));
    chk("arst_out_dout", 64'(out_dout), 64'(0));
    chk("arst_errs", 64'({ovf_err, unx_err}), 64'(0));
    model_reset();
    repeat (2) cycle();
    #2 rst = 1'b1;
    cycle();
    chk("post_rst_out_vld", 64'(out_vld), 64'(0));
    chk("post_rst_cl_rdy", 64'(cl_rdy), 64'(2'b11));

    // random traffic on both ports
    repeat (400) begin
      ready = ($urandom_range(0, 7) != 0);
      cl_read = NUMRDPT'($urandom);
      out_rdy = NUMRDPT'($urandom);
      cycle();
    end
    cl_read = '0;
    out_rdy = '1;
    ready = 1'b1;
    repeat (LAT + 8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
